// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register bank: default geometry and the
// packed read-port slice offset used by both the bank and its interface users.
package regfile_pkg;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 16;
  localparam int NUM_RD_DEF   = 2;

  function automatic int rd_off(input int port, input int width);
    return port * width;
  endfunction
endpackage

// File: rtl/regfile_bank_p_if.sv
// Register bank bus: ALU write port, load issue/return path, packed read ports
// and scoreboard status. master drives requests, slave is the bank.
interface regfile_bank_p_if import regfile_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = NUM_RD_DEF
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic                     alu_we;
  logic [ADDR_W-1:0]        alu_waddr;
  logic [DATA_W-1:0]        alu_wdata;
  logic                     ld_issue;
  logic [ADDR_W-1:0]        ld_dest;
  logic                     ld_issue_ready;
  logic                     ld_valid;
  logic [ADDR_W-1:0]        ld_waddr;
  logic [DATA_W-1:0]        ld_wdata;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_REGS-1:0]      busy_vec;
  logic                     ld_err;

  modport master (
    output alu_we, alu_waddr, alu_wdata, ld_issue, ld_dest,
           ld_valid, ld_waddr, ld_wdata, rd_addr,
    input  ld_issue_ready, rd_data, rd_busy, busy_vec, ld_err
  );

  modport slave (
    input  alu_we, alu_waddr, alu_wdata, ld_issue, ld_dest,
           ld_valid, ld_waddr, ld_wdata, rd_addr,
    output ld_issue_ready, rd_data, rd_busy, busy_vec, ld_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Load scoreboard: one busy bit per register with an outstanding load, the
// issue-ready check, and a sticky error for returns to non-busy registers.
module regfile_scoreboard #(
  parameter  int NUM_REGS = 16,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ld_issue,
  input  logic [ADDR_W-1:0]   ld_dest,
  input  logic                ld_valid,
  input  logic [ADDR_W-1:0]   ld_waddr,
  output logic                ld_issue_ready,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                ld_err
);
  logic                accept;
  logic [NUM_REGS-1:0] busy_next;

  assign ld_issue_ready = ~busy_vec[ld_dest];
  assign accept         = ld_issue & ld_issue_ready;

  // Set after clear: a new load to the returning register stays outstanding.
  always_comb begin
    busy_next = busy_vec;
    if (ld_valid) busy_next[ld_waddr] = 1'b0;
    if (accept)   busy_next[ld_dest]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec <= '0;
      ld_err   <= 1'b0;
    end else begin
      busy_vec <= busy_next;
      if (ld_valid && !busy_vec[ld_waddr]) ld_err <= 1'b1;
    end
  end
endmodule

// File: rtl/regfile_bank_p.sv
// Dual-write register bank with NUM_RD read ports and a load scoreboard.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module regfile_bank_p import regfile_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_RD   = NUM_RD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  regfile_bank_p_if.slave  bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  // Load write is applied last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      if (bus.alu_we)   regs[bus.alu_waddr] <= bus.alu_wdata;
      if (bus.ld_valid) regs[bus.ld_waddr]  <= bus.ld_wdata;
    end
  end

  regfile_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk            (clk),
    .rst_n          (rst_n),
    .ld_issue       (bus.ld_issue),
    .ld_dest        (bus.ld_dest),
    .ld_valid       (bus.ld_valid),
    .ld_waddr       (bus.ld_waddr),
    .ld_issue_ready (bus.ld_issue_ready),
    .busy_vec       (bus.busy_vec),
    .ld_err         (bus.ld_err)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = bus.rd_addr[rd_off(i, ADDR_W) +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    logic ld_hit, alu_hit;
    assign ld_hit  = bus.ld_valid & (bus.ld_waddr  == addr);
    assign alu_hit = bus.alu_we   & (bus.alu_waddr == addr);
    assign bus.rd_data[rd_off(i, DATA_W) +: DATA_W] =
      ld_hit ? bus.ld_wdata : (alu_hit ? bus.alu_wdata : regs[addr]);
    assign bus.rd_busy[i] = bus.busy_vec[addr] & ~ld_hit;
`else
    assign bus.rd_data[rd_off(i, DATA_W) +: DATA_W] = regs[addr];
    assign bus.rd_busy[i] = bus.busy_vec[addr];
`endif
  end
endmodule

// File: tb/tb_regfile_bank_p.sv
// Randomized + directed bench for regfile_bank_p against an array-based model.
module tb_regfile_bank_p;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int RD = 2;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_busy;
  logic          m_err;

  always #5 clk = ~clk;

  regfile_bank_p_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(RD)) bus ();

  regfile_bank_p #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) m_regs[r] = '0;
    m_busy = '0;
    m_err  = 1'b0;
  endtask

  task automatic idle();
    bus.alu_we = 0; bus.alu_waddr = '0; bus.alu_wdata = '0;
    bus.ld_issue = 0; bus.ld_dest = '0;
    bus.ld_valid = 0; bus.ld_waddr = '0; bus.ld_wdata = '0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    bus.rd_addr = {4'(a1), 4'(a0)};
  endtask

  task automatic check_outputs();
    logic [AW-1:0] a;
    logic [DW-1:0] ed;
    logic          eb;
    for (int p = 0; p < RD; p++) begin
      a  = bus.rd_addr[p*AW +: AW];
      ed = m_regs[a];
      eb = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (bus.alu_we && bus.alu_waddr == a) ed = bus.alu_wdata;
      if (bus.ld_valid && bus.ld_waddr == a) begin ed = bus.ld_wdata; eb = 1'b0; end
`endif
      chk($sformatf("rd_data%0d", p), 64'(bus.rd_data[p*DW +: DW]), 64'(ed));
      chk($sformatf("rd_busy%0d", p), 64'(bus.rd_busy[p]), 64'(eb));
    end
    chk("busy_vec", 64'(bus.busy_vec), 64'(m_busy));
    chk("ld_err", 64'(bus.ld_err), 64'(m_err));
    chk("issue_ready", 64'(bus.ld_issue_ready), 64'(!m_busy[bus.ld_dest]));
  endtask

  // Reference update from the written rules: readiness judged on the old
  // scoreboard, return clears, accepted issue sets afterwards, load data wins.
  task automatic model_edge();
    bit acc;
    if (!rst_n) return;
    acc = bus.ld_issue && !m_busy[bus.ld_dest];
    if (bus.ld_valid) begin
      if (!m_busy[bus.ld_waddr]) m_err = 1'b1;
      m_busy[bus.ld_waddr] = 1'b0;
    end
    if (acc) m_busy[bus.ld_dest] = 1'b1;
    if (bus.alu_we)   m_regs[bus.alu_waddr] = bus.alu_wdata;
    if (bus.ld_valid) m_regs[bus.ld_waddr]  = bus.ld_wdata;
  endtask

  // Called just after a negedge with inputs set; returns at the next negedge, idle.
  task automatic cyc();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    idle();
  endtask

  initial begin
    int q[$];
    idle();
    set_rd(0, 1);
    model_reset();
    @(negedge clk);
    #1 check_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Preload registers, leave a load outstanding and trip the error flag.
    for (int r = 0; r < NR; r++) begin
      bus.alu_we = 1; bus.alu_waddr = AW'(r); bus.alu_wdata = $urandom;
      cyc();
    end
    bus.ld_issue = 1; bus.ld_dest = 4'd1; cyc();
    bus.ld_valid = 1; bus.ld_waddr = 4'd0; bus.ld_wdata = 32'h1234; cyc();
    chk("pre_busy1", 64'(bus.busy_vec[1]), 64'd1);
    chk("pre_err", 64'(bus.ld_err), 64'd1);

    // Asynchronous reset mid-cycle clears everything without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd_data", 64'(bus.rd_data), 64'd0);
    chk("rst_busy", 64'(bus.busy_vec), 64'd0);
    chk("rst_err", 64'(bus.ld_err), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // ALU write visible on read port 0.
    set_rd(3, 5);
    bus.alu_we = 1; bus.alu_waddr = 4'd3; bus.alu_wdata = 32'hA5A5_0001;
`ifdef REGFILE_BYPASS_EN
    #1 chk("alu3_bypass", 64'(bus.rd_data[31:0]), 64'h0000_0000_A5A5_0001);
`else
    #1 chk("alu3_before", 64'(bus.rd_data[31:0]), 64'd0);
`endif
    cyc();
    #1 chk("alu3_after", 64'(bus.rd_data[31:0]), 64'h0000_0000_A5A5_0001);

    // Collision on reg 5: load wins (issue first so no error is raised).
    bus.ld_issue = 1; bus.ld_dest = 4'd5; cyc();
    bus.alu_we = 1; bus.alu_waddr = 4'd5; bus.alu_wdata = 32'h1111;
    bus.ld_valid = 1; bus.ld_waddr = 4'd5; bus.ld_wdata = 32'h2222;
    cyc();
    #1 chk("coll5", 64'(bus.rd_data[63:32]), 64'h2222);

    // Load to reg 7: issue, refused reissue, return.
    set_rd(7, 7);
    bus.ld_issue = 1; bus.ld_dest = 4'd7; cyc();
    chk("busy7_set", 64'(bus.busy_vec[7]), 64'd1);
    bus.ld_issue = 1; bus.ld_dest = 4'd7;
    #1 chk("ready7_low", 64'(bus.ld_issue_ready), 64'd0);
    cyc();
    chk("busy7_hold", 64'(bus.busy_vec), 64'h0080);
    bus.ld_valid = 1; bus.ld_waddr = 4'd7; bus.ld_wdata = 32'hDEAD_BEEF; cyc();
    chk("busy7_clr", 64'(bus.busy_vec[7]), 64'd0);
    #1 chk("reg7", 64'(bus.rd_data[31:0]), 64'h0000_0000_DEAD_BEEF);
    chk("err_clean", 64'(bus.ld_err), 64'd0);

    // Return to non-busy reg 9 sets the sticky error.
    bus.ld_valid = 1; bus.ld_waddr = 4'd9; bus.ld_wdata = 32'h99; cyc();
    chk("err9", 64'(bus.ld_err), 64'd1);

    // Same-cycle issue and return on reg 2: set wins, data written.
    set_rd(2, 9);
    bus.ld_issue = 1; bus.ld_dest = 4'd2;
    bus.ld_valid = 1; bus.ld_waddr = 4'd2; bus.ld_wdata = 32'h0BAD_0002;
    cyc();
    chk("busy2_set", 64'(bus.busy_vec[2]), 64'd1);
    #1 chk("reg2", 64'(bus.rd_data[31:0]), 64'h0000_0000_0BAD_0002);

    for (int k = 0; k < 5; k++) begin
      bus.alu_we = 1; bus.alu_waddr = AW'($urandom); bus.alu_wdata = $urandom;
      cyc();
    end
    chk("err_sticky", 64'(bus.ld_err), 64'd1);

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        continue;
      end
      q.delete();
      for (int r = 0; r < NR; r++) if (m_busy[r]) q.push_back(r);
      bus.alu_we    = 1'($urandom);
      bus.alu_waddr = AW'($urandom);
      bus.alu_wdata = $urandom;
      bus.ld_issue  = 1'($urandom);
      bus.ld_dest   = AW'($urandom);
      bus.ld_valid  = ($urandom_range(0, 2) == 0);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        bus.ld_waddr = AW'(q[$urandom_range(0, q.size() - 1)]);
      else
        bus.ld_waddr = AW'($urandom);
      bus.ld_wdata  = $urandom;
      set_rd(($urandom_range(0, 2) == 0) ? int'(bus.ld_waddr) : int'($urandom_range(0, NR - 1)),
             ($urandom_range(0, 2) == 0) ? int'(bus.alu_waddr) : int'($urandom_range(0, NR - 1)));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_bank_p.md
Name: regfile_bank_p

Overview:
Parametrised, clocked successor to the processor register bank. Holds NUM_REGS registers of DATA_W bits and has two write ports: the ALU result port and the load-return port. Provides NUM_RD combinational read ports and a load scoreboard that marks destinations with an outstanding memory load as busy. Sits between decode/ALU and the RAM load path.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 16, register count; must be a power of two, at least 2
NUM_RD, 2, number of read ports
ADDR_W, $clog2(NUM_REGS), derived localparam; not overridable

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
alu_we  in  1  ALU write enable
alu_waddr  in  ADDR_W  ALU destination register
alu_wdata  in  DATA_W  ALU result
ld_issue  in  1  load issued to RAM; marks ld_dest busy
ld_dest  in  ADDR_W  destination of the issued load
ld_issue_ready  out  1  low when ld_dest is already busy
ld_valid  in  1  load data returning this cycle
ld_waddr  in  ADDR_W  destination of the returning load
ld_wdata  in  DATA_W  returning load data
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses slice i
rd_data  out  NUM_RD*DATA_W  packed read data
rd_busy  out  NUM_RD  per-port busy flag of the addressed register
busy_vec  out  NUM_REGS  scoreboard, one bit per register
ld_err  out  1  sticky flag: load returned to a non-busy register

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, busy_vec 0, ld_err 0. Reset mid-operation drops all pending loads. Late ld_valid after reset still writes data and sets ld_err.
- Writes: take effect at the rising edge. With alu_we=1, reg[alu_waddr] <= alu_wdata. With ld_valid=1, reg[ld_waddr] <= ld_wdata.
- Same-address write collision (alu_we, ld_valid, and alu_waddr==ld_waddr): load data wins. Different addresses: both writes occur.
- Reads: rd_data slice i = reg[rd_addr slice i], combinational from stored state. Without bypass, a write is visible the cycle after its edge. rd_busy[i] = busy_vec[rd_addr slice i].
- ld_issue_ready = !busy_vec[ld_dest], combinational.
- Load accepted only when ld_issue and ld_issue_ready are both high. An accepted load sets busy_vec[ld_dest] at the edge. A refused issue changes nothing.
- ld_valid clears busy_vec[ld_waddr] at the edge. If that bit was already 0, ld_err is set and stays set until reset; the data is still written.
- Accepted issue and return in the same cycle, same register: the set wins, so busy stays 1 (new load outstanding). Different registers: both updates apply.
- ALU write to a busy register: data is written and busy is unchanged; the later load return overwrites it.
- All index arithmetic is ADDR_W bits with no wrap or out-of-range handling, because NUM_REGS is a power of two.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-through forwarding. If a read address matches a same-cycle write, rd_data returns the incoming data, with load data taking priority over ALU data. rd_busy[i] reads 0 when ld_valid targets that register this cycle.
- Undefined: reads return stored state only, as described in Behaviour.

Decomposition:
- Package regfile_pkg holds the default DATA_W and NUM_REGS and a function returning the read-port slice offset. rd_addr and rd_data stay packed vectors.
- One sub-module, regfile_scoreboard, owns busy_vec, ld_issue_ready, and ld_err.
- The data array, the write-priority logic, and the read muxes stay in regfile_bank_p.

Test Plan:
- Reset with registers preloaded, then rst_n low mid-cycle -> immediately all rd_data 0, busy_vec 0, ld_err 0.
- alu_we=1, alu_waddr=3, alu_wdata=32'hA5A5_0001; read port 0 at address 3 -> rd_data shows the value one cycle after the edge (same cycle with bypass).
- Same cycle: alu_we to reg 5 with 32'h1111 and ld_valid to reg 5 with 32'h2222 -> reg 5 = 32'h2222.
- Issue load to reg 7 -> busy_vec[7]=1. Re-issue to 7 -> ld_issue_ready=0 and no change. ld_valid to 7 with 32'hDEAD_BEEF -> busy clears and reg 7 = 32'hDEAD_BEEF.
- Issue to reg 2 while load to reg 2 returns in the same cycle -> busy_vec[2] stays 1 and reg 2 holds the returned data.
- ld_valid to non-busy reg 9 -> ld_err=1 and stays 1 across later traffic until rst_n.
